mprj_seq_monitor: RTL
=====================

// Module: mprj_seq_monitor
// PURPOSE
//  Parametrised in-order output-sequence monitor for user-project IO results (FPU and similar).
//  Holds an expected-value table and arms on a ready strobe. It then waits for each expected word to appear stably on obs_data, in table order.
//  Reports pass, timeout or abort with the failing index. Replaces hand-written chains of wait() statements.
//  Synthesizable; sits between the mprj_io observation bus and the bench or an on-chip status register.
// PARAMETERS
//  DATA_W      32      width of observed/expected words
//  DEPTH       16      expected-table entries (power of 2, >=2); IDX_W = $clog2(DEPTH)
//  STABLE_CYC  4       consecutive equal cycles required to accept a match (>=1)
//  TIMEOUT_CYC 300000  max cycles allowed between matches (and from arm to first match)
//  STRICT      1       1: obs_data must change after a match before the next entry is compared; 0: immediate compare
// PORTS
//  clock      in   1       system clock
//  resetb     in   1       asynchronous active-low reset
//  exp_we     in   1       write expected table entry (ignored while busy)
//  exp_waddr  in   IDX_W   table write address
//  exp_wdata  in   DATA_W  expected value
//  exp_wmask  in   DATA_W  compare mask, 1=bit checked (used only with SEQMON_MASK_EN)
//  exp_count  in   IDX_W+1 number of valid entries, 1..DEPTH; sampled on start
//  start      in   1       pulse: begin a run (ignored while busy)
//  ready      in   1       level: DUT ready (mprj_ready); checking begins on first high after start
//  abort      in   1       pulse: abandon run
//  obs_data   in   DATA_W  observed output word
//  busy       out  1       run in progress (ARM or CHECK)
//  pass       out  1       sticky: all entries matched
//  timeout    out  1       sticky: TIMEOUT_CYC elapsed without a match
//  match_idx  out  IDX_W+1 entries matched so far in current run
//  last_obs   out  DATA_W  obs_data registered at the cycle the run ended
// BEHAVIOUR
//  Reset: FSM=IDLE; busy=0, pass=0, timeout=0, match_idx=0, last_obs=0; table contents unaffected (no reset on RAM).
//  States: IDLE -start-> ARM -ready==1-> CHECK -all matched-> DONE; CHECK -timer expiry-> DONE (timeout); ARM/CHECK -abort-> IDLE.
//  start in IDLE or DONE clears pass/timeout/match_idx, latches exp_count. exp_count of 0 or >DEPTH is clamped to DEPTH.
//  ARM: timer held at 0; ARM itself never times out.
//  CHECK: cmp = (obs_data & m) == (exp[idx] & m). Without SEQMON_MASK_EN, m is all ones.
//   Stability counter increments while cmp holds; cleared on any cycle cmp is false or obs_data changes.
//   Match is accepted in the cycle the counter reaches STABLE_CYC: idx++, match_idx++, timer and stability counter cleared.
//   STRICT=1: after a match, compare is gated off until obs_data differs from its value at match. Repeated equal entries therefore need a real transition.
//   STRICT=0: next entry is compared from the following cycle, so identical consecutive entries pass after STABLE_CYC cycles each.
//  Non-matching values are ignored (no fail on mismatch); only the timer ends a run unsuccessfully.
//  Timer increments every CHECK cycle. On reaching TIMEOUT_CYC: timeout=1, last_obs=obs_data, ->DONE.
//  Last entry matched: pass=1, last_obs=obs_data, ->DONE. If match and timeout coincide, the match wins (pass=1, timeout=0).
//  busy=1 exactly in ARM and CHECK; pass/timeout remain valid in DONE until next start.
//  abort takes priority over a same-cycle match or expiry. abort returns to IDLE with pass=0, timeout=0; match_idx is held for debug.
//  exp_we while busy is dropped. exp_we and start in the same cycle from IDLE: the write completes, then the run starts with the new table.
//  Reset mid-run returns to IDLE immediately; no partial status is retained.
// CONFIGURATION
//  SEQMON_MASK_EN defined: a per-entry mask RAM is written with exp_wmask on exp_we, and only masked bits are compared.
//   Used for F2I/fclass words where only low bits matter.
//  SEQMON_MASK_EN undefined: no mask storage; exp_wmask ignored; full-width compare.
// TESTING
//  1 Load 15 FPU add/sub words (0x421FAF69 .. 0xBEB465E8), start, ready=1, drive them in order, each held 10 cycles -> pass=1 after 15th, match_idx=15.
//  2 Same table, DUT stalls after entry 5, TIMEOUT_CYC=1000 -> timeout=1 at 1000 cycles after 5th match, match_idx=5, pass=0.
//  3 STRICT=1, table {0x40,0x40,0x02}, obs 0x40 held then 0x02 -> match_idx stops at 1, timeout. Obs 0x40,0x41,0x40,0x02 -> pass.
//  4 STABLE_CYC=4, exp 0x4208ED91 with a 2-cycle glitch to that value, then steady for 4 cycles -> glitch ignored, match on the 4th steady cycle.
//  5 abort in CHECK on the same cycle as a final match; then resetb low mid-run -> IDLE, pass=0, busy=0, all outputs at reset values.
//  6 SEQMON_MASK_EN: exp 0x00000040 with mask 0x000003FF, obs 0xABCD0040 -> match. With macro off, the same stimulus -> timeout.

Source files
------------

// File: rtl/mprj_seq_monitor_if.sv
// Observation/control bundle for mprj_seq_monitor.
//   master: bench or host side. It drives the table writes, the run control and obs_data,
//           and it receives the status outputs.
//   slave : the monitor itself.
// Ports carried:
//   exp_we/exp_waddr/exp_wdata/exp_wmask   expected-table write port
//   exp_count                              number of valid entries (sampled on start)
//   start/ready/abort                      run control
//   obs_data                               observed word
//   busy/pass/timeout/match_idx/last_obs   run status
interface mprj_seq_monitor_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic              exp_we;
  logic [IDX_W-1:0]  exp_waddr;
  logic [DATA_W-1:0] exp_wdata;
  logic [DATA_W-1:0] exp_wmask;
  logic [IDX_W:0]    exp_count;
  logic              start;
  logic              ready;
  logic              abort;
  logic [DATA_W-1:0] obs_data;
  logic              busy;
  logic              pass;
  logic              timeout;
  logic [IDX_W:0]    match_idx;
  logic [DATA_W-1:0] last_obs;

  modport master (
    output exp_we, exp_waddr, exp_wdata, exp_wmask, exp_count, start, ready, abort, obs_data,
    input  busy, pass, timeout, match_idx, last_obs
  );

  modport slave (
    input  exp_we, exp_waddr, exp_wdata, exp_wmask, exp_count, start, ready, abort, obs_data,
    output busy, pass, timeout, match_idx, last_obs
  );
endinterface

// File: rtl/mprj_seq_monitor.sv
// In-order output-sequence monitor.
// An expected-word table is loaded first. A start pulse arms the monitor, and checking begins
// once ready is high. Each table entry must then appear stably on obs_data, in order. The run
// ends with pass, with timeout (no match within TIMEOUT_CYC cycles), or back in idle on abort.
// Ports:
//   clock   system clock
//   resetb  asynchronous active-low reset
//   bus     mprj_seq_monitor_if.slave (table write, run control, obs_data, status)
// Optional feature: define SEQMON_MASK_EN to add a per-entry compare-mask RAM loaded from
// exp_wmask. Without it, every bit is compared.
module mprj_seq_monitor #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 300000,
  parameter bit          STRICT      = 1'b1
) (
  input logic               clock,
  input logic               resetb,
  mprj_seq_monitor_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned STB_W = $clog2(STABLE_CYC + 1);

  typedef enum logic [1:0] {StIdle, StArm, StCheck, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [STB_W-1:0]  stab_q, stab_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] last_obs_q, last_obs_d;
  logic [DATA_W-1:0] prev_obs_q;
  logic              gate_q, gate_d;
  logic [DATA_W-1:0] gate_val_q, gate_val_d;

  logic              busy;
  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] cmp_mask;
  logic              gated;
  logic              cmp;
  logic [STB_W-1:0]  stab_next;
  logic [TMR_W-1:0]  timer_inc;
  logic              match;
  logic              expire;
  logic              last_entry;

  assign busy = (state_q == StArm) || (state_q == StCheck);

  // Table RAM has no reset; writes are dropped while a run is in progress.
  always_ff @(posedge clock) begin
    if (bus.exp_we && !busy) begin
      exp_mem[bus.exp_waddr] <= bus.exp_wdata;
    end
  end

  assign exp_word = exp_mem[idx_q[IDX_W-1:0]];

`ifdef SEQMON_MASK_EN
  logic [DATA_W-1:0] mask_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (bus.exp_we && !busy) begin
      mask_mem[bus.exp_waddr] <= bus.exp_wmask;
    end
  end

  assign cmp_mask = mask_mem[idx_q[IDX_W-1:0]];
`else
  logic unused_wmask;
  assign unused_wmask = ^bus.exp_wmask;
  assign cmp_mask     = '1;
`endif

  // Strict mode holds the compare off until obs_data leaves the value it had at the last match.
  assign gated = STRICT && gate_q && (bus.obs_data == gate_val_q);
  assign cmp   = !gated && ((bus.obs_data & cmp_mask) == (exp_word & cmp_mask));

  // A cycle where obs_data has just changed to a matching value counts as the first stable cycle.
  always_comb begin
    stab_next = '0;
    if (cmp) begin
      stab_next = (bus.obs_data == prev_obs_q) ? stab_q + 1'b1 : STB_W'(1);
    end
  end

  assign timer_inc  = timer_q + 1'b1;
  assign match      = (state_q == StCheck) && (stab_next == STB_W'(STABLE_CYC));
  assign expire     = (state_q == StCheck) && (timer_inc == TMR_W'(TIMEOUT_CYC));
  assign last_entry = (idx_q + 1'b1) == count_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    stab_d     = stab_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    last_obs_d = last_obs_q;
    gate_d     = gate_q;
    gate_val_d = gate_val_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d   = StArm;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          idx_d     = '0;
          timer_d   = '0;
          stab_d    = '0;
          gate_d    = 1'b0;
          if (bus.exp_count == '0 || bus.exp_count > CNT_W'(DEPTH)) begin
            count_d = CNT_W'(DEPTH);
          end else begin
            count_d = bus.exp_count;
          end
        end
      end
      StArm: begin
        timer_d = '0;
        stab_d  = '0;
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.ready) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (bus.abort) begin
          // Abort beats a same-cycle match or expiry; match_idx is kept for debug.
          state_d   = StIdle;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
        end else begin
          timer_d = timer_inc;
          stab_d  = stab_next;
          if (gate_q && bus.obs_data != gate_val_q) begin
            gate_d = 1'b0;
          end
          if (match) begin
            idx_d   = idx_q + 1'b1;
            timer_d = '0;
            stab_d  = '0;
            if (STRICT) begin
              gate_d     = 1'b1;
              gate_val_d = bus.obs_data;
            end
            if (last_entry) begin
              pass_d     = 1'b1;
              last_obs_d = bus.obs_data;
              state_d    = StDone;
            end
          end else if (expire) begin
            timeout_d  = 1'b1;
            last_obs_d = bus.obs_data;
            state_d    = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= StIdle;
      count_q    <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      stab_q     <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      last_obs_q <= '0;
      prev_obs_q <= '0;
      gate_q     <= 1'b0;
      gate_val_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      stab_q     <= stab_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      last_obs_q <= last_obs_d;
      prev_obs_q <= bus.obs_data;
      gate_q     <= gate_d;
      gate_val_q <= gate_val_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.pass      = pass_q;
  assign bus.timeout   = timeout_q;
  assign bus.match_idx = idx_q;
  assign bus.last_obs  = last_obs_q;

endmodule
